ol_rx_mon: RTL and testbench
============================

// Module: ol_rx_mon
// PURPOSE
// Receive-side optical-link monitor/deframer. Consumes the 16-bit word stream recovered by the
// transceiver RX, which carries the far-end idle stream (16'h50BC) and framed data packets.
// Acquires and holds link lock, reports far-end LIVE, strips framing, checks each packet
// and hands payload to the downstream readout.
// PARAMETERS
// LOCK_CNT    16   consecutive idle words required to declare lock
// UNLOCK_CNT  4    consecutive invalid words that drop lock
// MAX_LEN     256  max payload words per packet, checksum word included
// PORTS
// clk          in   1   link word clock, all logic on rising edge
// reset        in   1   synchronous, active-high
// rx_data      in   16  received word, one per clk
// rx_datak     in   2   K flags; bit0 = low byte, bit1 = high byte
// link_locked  out  1   lock acquired
// remote_live  out  1   far-end LIVE, from the most recent idle word
// out_valid    out  1   payload word strobe
// out_data     out  16  payload word
// out_sop      out  1   with out_valid: first payload word of the packet
// pkt_done     out  1   1-cycle pulse: packet closed (EOP or abort)
// pkt_err      out  1   qualified by pkt_done: packet bad
// err_count    out  16  invalid-word count, saturates at 16'hFFFF
// pkt_count    out  16  good packets, wraps at 2^16
// BEHAVIOUR
// Word classes, decoded from rx_data/rx_datak each cycle:
// - IDLE_NL: 16'h50BC, datak 2'b11 (far end not live)
// - IDLE_L: 16'h50BC, datak 2'b00 (far end live)
// - SOP: 16'h55FB, datak 2'b01
// - EOP: 16'hAAFD, datak 2'b01
// - DATA: any other word with datak 2'b00
// - INVALID: everything else
// DATA is checked before IDLE_L only in terms of value: a 16'h50BC word with datak 2'b00 is
// always IDLE_L, never payload.
// Reset values: all outputs 0; state UNLOCKED; all counters, XOR accumulator and hold register cleared.
// States:
// - UNLOCKED: count consecutive IDLE_*. Any other class zeroes the count. When the count
//   reaches LOCK_CNT, go to LOCKED; link_locked rises the next cycle.
// - LOCKED: IDLE_* updates remote_live (1 for IDLE_L, 0 for IDLE_NL). SOP goes to IN_PKT
//   and clears len, the XOR accumulator and hold_valid. DATA or EOP outside a packet is
//   ignored and is not an error.
// - IN_PKT, on DATA:
//   - If hold_valid, emit the hold register, with out_sop=1 if it is the first emitted word.
//   - Load hold with the word, set hold_valid, XOR-accumulate it, and increment len.
//   - If len would exceed MAX_LEN: abort with pkt_err=1, go to LOCKED, drop the rest.
// - IN_PKT, on EOP: pkt_done pulses.
//   - pkt_err=1 if len<2 or the accumulated XOR != 0.
//   - The hold word is the checksum word and is never emitted.
//   - On a good packet, pkt_count increments. Go to LOCKED.
// - IN_PKT, on SOP: close the current packet with pkt_err=1 and start a new one in the same cycle.
// - IN_PKT, on IDLE_*: abort with pkt_err=1, go to LOCKED. remote_live is updated.
// INVALID handling, any state:
// - err_count increments, saturating.
// - In IN_PKT the packet is aborted with pkt_err=1.
// - In LOCKED/IN_PKT, UNLOCK_CNT consecutive INVALID words go to UNLOCKED. link_locked falls
//   the next cycle and remote_live clears.
// Latency:
// - Payload word W(i) is presented the cycle after W(i+1) is sampled. The final data word is
//   presented the cycle after the checksum word is sampled.
// - pkt_done is presented the cycle after EOP/abort is sampled.
// - out_valid and pkt_done may be high in the same cycle only for the SOP-in-IN_PKT case
//   (old packet close), and never for that same packet's words.
// Reset mid-packet: no pkt_done is produced; the state returns to UNLOCKED.
// Checksum: the sender makes the XOR of all payload words, checksum word included, equal to 16'h0000.
// TESTING
// 1. Lock: 15 x IDLE_NL -> link_locked=0; 16th -> link_locked=1, remote_live=0.
//    Then one IDLE_L -> remote_live=1.
// 2. Good packet: locked, then SOP, 16'h1234, 16'hABCD, 16'hB9F9 (checksum), EOP ->
//    out 1234 (sop=1), ABCD (sop=0); pkt_done with pkt_err=0; pkt_count=1.
// 3. Bad checksum: same packet with checksum 16'h0000 -> both words out; pkt_err=1; pkt_count unchanged.
// 4. Abort: SOP, 16'h0001, IDLE_L -> nothing emitted, pkt_done with pkt_err=1.
//    Second case: SOP, SOP -> pkt_err=1 for the first packet, second packet decodes normally.
// 5. Length: MAX_LEN+1 DATA words after SOP -> abort at word MAX_LEN+1 with pkt_err=1;
//    the following EOP is ignored.
// 6. Unlock: 3 INVALID words (datak 2'b10) -> still locked, err_count=3.
//    A 4th -> link_locked=0, remote_live=0, err_count=4.
//    Also: force err_count to 16'hFFFF -> it stays at 16'hFFFF.

Source files
------------

// File: rtl/ol_rx_mon.sv
// rtl/ol_rx_mon.sv - receive-side optical-link lock monitor and packet deframer
//
// Purpose: classifies each received 16-bit word, acquires/holds link lock from the
// idle stream, tracks far-end LIVE, strips SOP/EOP framing, verifies the XOR
// checksum and length of each packet and streams payload words downstream.
// The last data word of a packet is the checksum and is never emitted, so every
// word is held one cycle until the next one proves it is not the checksum.
//
// Ports:
//   clk          in   link word clock, rising edge
//   reset        in   synchronous, active-high
//   rx_data      in   received word, one per clk
//   rx_datak     in   K flags (bit0 low byte, bit1 high byte)
//   link_locked  out  lock acquired
//   remote_live  out  far-end LIVE from the most recent idle word
//   out_valid    out  payload word strobe
//   out_data     out  payload word
//   out_sop      out  first payload word of the packet (with out_valid)
//   pkt_done     out  1-cycle pulse when a packet closes (EOP or abort)
//   pkt_err      out  packet bad, qualified by pkt_done
//   err_count    out  invalid-word count, saturating
//   pkt_count    out  good-packet count, wrapping
module ol_rx_mon #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int MAX_LEN    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_datak,
  output logic        link_locked,
  output logic        remote_live,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_sop,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [15:0] err_count,
  output logic [15:0] pkt_count
);
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int ICW = $clog2(UNLOCK_CNT + 1);
  localparam int LNW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_IN_PKT} state_e;
  typedef enum logic [2:0] {C_IDLE_NL, C_IDLE_L, C_SOP, C_EOP, C_DATA, C_INVALID} cls_e;

  state_e         state_q, state_d;
  cls_e           cls;
  logic           is_idle, start_pkt, abort_pkt;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [ICW-1:0] inv_cnt_q, inv_cnt_d;
  logic [LNW-1:0] len_q, len_d;
  logic [15:0]    xor_q, xor_d, hold_q, hold_d;
  logic           hold_valid_q, hold_valid_d;
  logic           sop_pend_q, sop_pend_d;
  logic           remote_live_q, remote_live_d;
  logic           out_valid_q, out_valid_d;
  logic [15:0]    out_data_q, out_data_d;
  logic           out_sop_q, out_sop_d;
  logic           pkt_done_q, pkt_done_d;
  logic           pkt_err_q, pkt_err_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;

  // 50BC with datak 00 is an idle, so idles are decoded before generic data.
  always_comb begin
    cls = C_INVALID;
    if (rx_data == 16'h50BC && rx_datak == 2'b11)      cls = C_IDLE_NL;
    else if (rx_data == 16'h50BC && rx_datak == 2'b00) cls = C_IDLE_L;
    else if (rx_data == 16'h55FB && rx_datak == 2'b01) cls = C_SOP;
    else if (rx_data == 16'hAAFD && rx_datak == 2'b01) cls = C_EOP;
    else if (rx_datak == 2'b00)                        cls = C_DATA;
  end

  assign is_idle = (cls == C_IDLE_NL) || (cls == C_IDLE_L);

  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    inv_cnt_d     = inv_cnt_q;
    len_d         = len_q;
    xor_d         = xor_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    sop_pend_d    = sop_pend_q;
    remote_live_d = remote_live_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    out_sop_d     = 1'b0;
    pkt_done_d    = 1'b0;
    pkt_err_d     = 1'b0;
    err_cnt_d     = err_cnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    start_pkt     = 1'b0;
    abort_pkt     = 1'b0;

    if (cls == C_INVALID && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;

    case (state_q)
      ST_UNLOCKED: begin
        if (is_idle) begin
          if (lock_cnt_q == LCW'(LOCK_CNT - 1)) begin
            state_d    = ST_LOCKED;
            lock_cnt_d = '0;
            inv_cnt_d  = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end else begin
          lock_cnt_d = '0;
        end
      end
      default: begin
        if (cls == C_INVALID) begin
          abort_pkt = (state_q == ST_IN_PKT);
          if (inv_cnt_q == ICW'(UNLOCK_CNT - 1)) begin
            state_d       = ST_UNLOCKED;
            inv_cnt_d     = '0;
            lock_cnt_d    = '0;
            remote_live_d = 1'b0;
          end else begin
            inv_cnt_d = inv_cnt_q + 1'b1;
            state_d   = ST_LOCKED;
          end
        end else begin
          inv_cnt_d = '0;
          if (is_idle) begin
            remote_live_d = (cls == C_IDLE_L);
            abort_pkt     = (state_q == ST_IN_PKT);
            state_d       = ST_LOCKED;
          end else if (cls == C_SOP) begin
            // An SOP inside a packet closes the old one as bad and restarts.
            abort_pkt = (state_q == ST_IN_PKT);
            start_pkt = 1'b1;
          end else if (state_q == ST_IN_PKT && cls == C_EOP) begin
            pkt_done_d = 1'b1;
            pkt_err_d  = (len_q < LNW'(2)) || (xor_q != 16'h0000);
            if (!pkt_err_d) pkt_cnt_d = pkt_cnt_q + 16'd1;
            state_d = ST_LOCKED;
          end else if (state_q == ST_IN_PKT && cls == C_DATA) begin
            if (len_q == LNW'(MAX_LEN)) begin
              abort_pkt = 1'b1;
              state_d   = ST_LOCKED;
            end else begin
              if (hold_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = hold_q;
                out_sop_d   = sop_pend_q;
                sop_pend_d  = 1'b0;
              end
              hold_d       = rx_data;
              hold_valid_d = 1'b1;
              xor_d        = xor_q ^ rx_data;
              len_d        = len_q + 1'b1;
            end
          end
        end
      end
    endcase

    if (abort_pkt) begin
      pkt_done_d = 1'b1;
      pkt_err_d  = 1'b1;
    end
    if (start_pkt) begin
      state_d      = ST_IN_PKT;
      len_d        = '0;
      xor_d        = 16'h0000;
      hold_valid_d = 1'b0;
      sop_pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_UNLOCKED;
      lock_cnt_q    <= '0;
      inv_cnt_q     <= '0;
      len_q         <= '0;
      xor_q         <= 16'h0000;
      hold_q        <= 16'h0000;
      hold_valid_q  <= 1'b0;
      sop_pend_q    <= 1'b0;
      remote_live_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 16'h0000;
      out_sop_q     <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_err_q     <= 1'b0;
      err_cnt_q     <= 16'h0000;
      pkt_cnt_q     <= 16'h0000;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      inv_cnt_q     <= inv_cnt_d;
      len_q         <= len_d;
      xor_q         <= xor_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      sop_pend_q    <= sop_pend_d;
      remote_live_q <= remote_live_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      pkt_done_q    <= pkt_done_d;
      pkt_err_q     <= pkt_err_d;
      err_cnt_q     <= err_cnt_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

  assign link_locked = (state_q != ST_UNLOCKED);
  assign remote_live = remote_live_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sop     = out_sop_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_err     = pkt_err_q;
  assign err_count   = err_cnt_q;
  assign pkt_count   = pkt_cnt_q;
endmodule

// File: tb/tb_ol_rx_mon.sv
// tb/tb_ol_rx_mon.sv - scoreboard testbench for ol_rx_mon
module tb_ol_rx_mon;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rx_data = 16'h0000;
  logic [1:0]  rx_datak = 2'b00;
  logic        link_locked, remote_live, out_valid, out_sop, pkt_done, pkt_err;
  logic [15:0] out_data, err_count, pkt_count;

  int total = 0;
  int bad = 0;
  logic [16:0] exp_w[$];
  logic        exp_d[$];
  logic [16:0] mon_w;
  logic        mon_e;
  logic [15:0] cs;

  always #5 clk = ~clk;

  ol_rx_mon dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
    .link_locked(link_locked), .remote_live(remote_live), .out_valid(out_valid),
    .out_data(out_data), .out_sop(out_sop), .pkt_done(pkt_done), .pkt_err(pkt_err),
    .err_count(err_count), .pkt_count(pkt_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] k);
    rx_data  = d;
    rx_datak = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_nl(); send(16'h50BC, 2'b11); endtask
  task automatic idle_l();  send(16'h50BC, 2'b00); endtask
  task automatic sop();     send(16'h55FB, 2'b01); endtask
  task automatic eop();     send(16'hAAFD, 2'b01); endtask
  task automatic inv();     send(16'h1234, 2'b10); endtask
  task automatic dat(input logic [15:0] d); send(d, 2'b00); endtask

  task automatic exp_word(input logic [15:0] d, input logic s); exp_w.push_back({s, d}); endtask
  task automatic exp_done(input logic e); exp_d.push_back(e); endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial forever begin
    @(negedge clk);
    if (out_valid) begin
      if (exp_w.size() == 0) begin
        total++; bad++;
        $display("FAIL word: got sop=%b data=%h want none", out_sop, out_data);
      end else begin
        mon_w = exp_w.pop_front();
        chk("word", 32'({out_sop, out_data}), 32'(mon_w));
      end
    end
    if (pkt_done) begin
      if (exp_d.size() == 0) begin
        total++; bad++;
        $display("FAIL done: got err=%b want none", pkt_err);
      end else begin
        mon_e = exp_d.pop_front();
        chk("done_err", 32'(pkt_err), 32'(mon_e));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(link_locked), 32'd0);
    chk("rst_live", 32'(remote_live), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    reset = 1'b0;

    // lock acquisition
    repeat (15) idle_nl();
    chk("lock15", 32'(link_locked), 32'd0);
    idle_nl();
    chk("lock16", 32'(link_locked), 32'd1);
    chk("live_nl", 32'(remote_live), 32'd0);
    idle_l();
    chk("live_l", 32'(remote_live), 32'd1);

    // good packet
    exp_word(16'h1234, 1'b1); exp_word(16'hABCD, 1'b0); exp_done(1'b0);
    sop(); dat(16'h1234); dat(16'hABCD); dat(16'hB9F9); eop(); idle_l();
    chk("good_pkt_count", 32'(pkt_count), 32'd1);

    // bad checksum
    exp_word(16'h1234, 1'b1); exp_word(16'hABCD, 1'b0); exp_done(1'b1);
    sop(); dat(16'h1234); dat(16'hABCD); dat(16'h0000); eop(); idle_l();
    chk("badcs_pkt_count", 32'(pkt_count), 32'd1);

    // abort by idle
    exp_done(1'b1);
    sop(); dat(16'h0001); idle_l(); idle_l();
    chk("abort_live", 32'(remote_live), 32'd1);

    // SOP inside packet, then a good packet
    exp_done(1'b1); exp_word(16'h1234, 1'b1); exp_word(16'hABCD, 1'b0); exp_done(1'b0);
    sop(); sop(); dat(16'h1234); dat(16'hABCD); dat(16'hB9F9); eop(); idle_l();
    chk("resop_pkt_count", 32'(pkt_count), 32'd2);

    // too short: one word only
    exp_done(1'b1);
    sop(); dat(16'h0000); eop(); idle_l();
    chk("short_pkt_count", 32'(pkt_count), 32'd2);

    // over-length: MAX_LEN+1 data words, trailing EOP ignored
    for (int i = 1; i <= 255; i++) exp_word(16'(i), (i == 1));
    exp_done(1'b1);
    sop();
    for (int i = 1; i <= 257; i++) dat(16'(i));
    eop(); idle_l();
    chk("long_pkt_count", 32'(pkt_count), 32'd2);

    // exactly MAX_LEN words including checksum: good
    cs = 16'h0000;
    for (int i = 1; i <= 255; i++) begin
      exp_word(16'(i), (i == 1));
      cs = cs ^ 16'(i);
    end
    exp_done(1'b0);
    sop();
    for (int i = 1; i <= 255; i++) dat(16'(i));
    dat(cs); eop(); idle_l();
    chk("max_pkt_count", 32'(pkt_count), 32'd3);

    // unlock on invalid words
    repeat (3) inv();
    chk("inv3_locked", 32'(link_locked), 32'd1);
    chk("inv3_err", 32'(err_count), 32'd3);
    inv();
    chk("inv4_locked", 32'(link_locked), 32'd0);
    chk("inv4_live", 32'(remote_live), 32'd0);
    chk("inv4_err", 32'(err_count), 32'd4);

    // relock, then invalid word aborts a packet
    repeat (16) idle_l();
    chk("relock", 32'(link_locked), 32'd1);
    exp_done(1'b1);
    sop(); dat(16'h0005); inv(); idle_l();
    chk("invpkt_err", 32'(err_count), 32'd5);
    chk("invpkt_locked", 32'(link_locked), 32'd1);

    // reset mid-packet: no pkt_done
    exp_word(16'h0011, 1'b1);
    sop(); dat(16'h0011); dat(16'h0022);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_locked", 32'(link_locked), 32'd0);
    chk("midrst_err", 32'(err_count), 32'd0);
    chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
    idle_nl(); idle_nl();

    // err_count saturation
    repeat (65534) inv();
    chk("sat_fffe", 32'(err_count), 32'h0000FFFE);
    inv();
    chk("sat_ffff", 32'(err_count), 32'h0000FFFF);
    inv();
    chk("sat_hold", 32'(err_count), 32'h0000FFFF);

    repeat (3) idle_nl();
    chk("left_words", 32'(exp_w.size()), 32'd0);
    chk("left_done", 32'(exp_d.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
